// File: rtl/dp_ram_bytewe.sv
// dp_ram_bytewe: single-clock true-dual-port RAM with per-byte write enables,
// selectable same-port read-during-write behaviour, optional output register
// stage, per-port read-valid flags and write/write collision detection.
//
// Port handshake: there is no backpressure. An access is taken on every rising
// clock edge where the port enable is high. va/vb qualify doa/dob in the cycle
// they are presented; a low valid means the data output is holding an older value.
module dp_ram_bytewe #(
    parameter int DATA_W   = 16,
    parameter int BYTE_W   = 8,
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 2048,
    parameter int RDW_MODE = 0,    // 0 read-first, 1 write-first, 2 no-change
    parameter int OUT_REG  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [DATA_W/BYTE_W-1:0]   wea,
    input  logic [ADDR_W-1:0]          addra,
    input  logic [DATA_W-1:0]          dia,
    input  logic                       enb,
    input  logic [DATA_W/BYTE_W-1:0]   web,
    input  logic [ADDR_W-1:0]          addrb,
    input  logic [DATA_W-1:0]          dib,
    output logic [DATA_W-1:0]          doa,
    output logic                       va,
    output logic [DATA_W-1:0]          dob,
    output logic                       vb,
    output logic                       coll
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_in, b_in, same_addr;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [NB-1:0]     a_lane, b_lane;
    logic [DATA_W-1:0] a_old, b_old;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_load, b_load;
    logic [DATA_W-1:0] doa1, dob1;
    logic              va1, vb1;

    assign a_in      = ({1'b0, addra} < DEPTH_LIM);
    assign b_in      = ({1'b0, addrb} < DEPTH_LIM);
    assign a_idx     = addra[IDX_W-1:0];
    assign b_idx     = addrb[IDX_W-1:0];
    assign same_addr = (addra == addrb);

    // Effective lane writes: disabled ports, out-of-range addresses and reset cycles write nothing.
    assign a_lane = (ena && a_in && !rst) ? wea : '0;
    assign b_lane = (enb && b_in && !rst) ? web : '0;

    // Old contents as seen by this cycle's reads; out-of-range reads return zero.
    assign a_old = a_in ? mem[a_idx] : '0;
    assign b_old = b_in ? mem[b_idx] : '0;

    // Memory array update; on a shared address port A owns lanes both ports write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (b_lane[i] && !(same_addr && a_lane[i]))
                mem[b_idx][i*BYTE_W +: BYTE_W] <= dib[i*BYTE_W +: BYTE_W];
            if (a_lane[i])
                mem[a_idx][i*BYTE_W +: BYTE_W] <= dia[i*BYTE_W +: BYTE_W];
        end
    end

    // Port A read selection: what to load into the first output stage, if anything.
    always_comb begin
        a_load = 1'b0;
        a_data = a_old;
        if (ena) begin
            if (|wea) begin
                if (RDW_MODE == 1) begin
                    a_load = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        if (a_lane[i])
                            a_data[i*BYTE_W +: BYTE_W] = dia[i*BYTE_W +: BYTE_W];
                        else if (b_lane[i] && same_addr)
                            a_data[i*BYTE_W +: BYTE_W] = dib[i*BYTE_W +: BYTE_W];
                    end
                end else if (RDW_MODE != 2) begin
                    a_load = 1'b1;
                end
            end else begin
                a_load = 1'b1;
            end
        end
    end

    // Port B read selection, mirroring port A but with port A winning shared lanes.
    always_comb begin
        b_load = 1'b0;
        b_data = b_old;
        if (enb) begin
            if (|web) begin
                if (RDW_MODE == 1) begin
                    b_load = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        if (a_lane[i] && same_addr)
                            b_data[i*BYTE_W +: BYTE_W] = dia[i*BYTE_W +: BYTE_W];
                        else if (b_lane[i])
                            b_data[i*BYTE_W +: BYTE_W] = dib[i*BYTE_W +: BYTE_W];
                    end
                end else if (RDW_MODE != 2) begin
                    b_load = 1'b1;
                end
            end else begin
                b_load = 1'b1;
            end
        end
    end

    // First output stage: data holds when nothing is loaded, valid follows the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            doa1 <= '0;
            va1  <= 1'b0;
            dob1 <= '0;
            vb1  <= 1'b0;
        end else begin
            va1 <= a_load;
            vb1 <= b_load;
            if (a_load) doa1 <= a_data;
            if (b_load) dob1 <= b_data;
        end
    end

    // Collision flag, registered once independent of the output pipeline depth.
    always_ff @(posedge clk) begin
        if (rst)
            coll <= 1'b0;
        else
            coll <= ena && enb && same_addr && a_in && (|wea) && (|web);
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] doa2, dob2;
            logic              va2, vb2;

            // Second output stage: valid advances every cycle, data only moves with a valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    doa2 <= '0;
                    va2  <= 1'b0;
                    dob2 <= '0;
                    vb2  <= 1'b0;
                end else begin
                    va2 <= va1;
                    vb2 <= vb1;
                    if (va1) doa2 <= doa1;
                    if (vb1) dob2 <= dob1;
                end
            end

            assign doa = doa2;
            assign va  = va2;
            assign dob = dob2;
            assign vb  = vb2;
        end else begin : g_no_out_reg
            assign doa = doa1;
            assign va  = va1;
            assign dob = dob1;
            assign vb  = vb1;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_bytewe.sv
// tb_dp_ram_bytewe: drives four RAM configurations from one stimulus stream
// (read-first, write-first, no-change, and a registered-output 1000-word
// variant) and compares them against a word-level memory model.
module tb_dp_ram_bytewe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena, enb;
    logic [1:0]  wea, web;
    logic [10:0] addra, addrb;
    logic [15:0] dia, dib;

    logic [15:0] doa_q [4];
    logic [15:0] dob_q [4];
    logic [3:0]  va_q, vb_q, coll_q;

    // c0: read-first, c1: write-first, c2: no-change, c3: out_reg + 1000 words
    dp_ram_bytewe #(.RDW_MODE(0)) u_rf (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib),
        .doa(doa_q[0]), .va(va_q[0]), .dob(dob_q[0]), .vb(vb_q[0]), .coll(coll_q[0]));
    dp_ram_bytewe #(.RDW_MODE(1)) u_wf (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib),
        .doa(doa_q[1]), .va(va_q[1]), .dob(dob_q[1]), .vb(vb_q[1]), .coll(coll_q[1]));
    dp_ram_bytewe #(.RDW_MODE(2)) u_nc (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .enb(enb), .web(web), .addrb(addrb), .dib(dib),
        .doa(doa_q[2]), .va(va_q[2]), .dob(dob_q[2]), .vb(vb_q[2]), .coll(coll_q[2]));
    dp_ram_bytewe #(.RDW_MODE(0), .OUT_REG(1), .DEPTH(1000), .ADDR_W(10)) u_or (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra[9:0]), .dia(dia),
        .enb(enb), .web(web), .addrb(addrb[9:0]), .dib(dib),
        .doa(doa_q[3]), .va(va_q[3]), .dob(dob_q[3]), .vb(vb_q[3]), .coll(coll_q[3]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic ea, input logic [1:0] wa, input logic [10:0] aa,
                         input logic [15:0] da, input logic eb, input logic [1:0] wb,
                         input logic [10:0] ab, input logic [15:0] db);
        rst = r; ena = ea; wea = wa; addra = aa; dia = da;
        enb = eb; web = wb; addrb = ab; dib = db;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0][15:0] doa;
        logic [3:0][15:0] dob;
        logic [3:0]       va;
        logic [3:0]       vb;
        logic [3:0]       coll;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] mm   [4][2048];
    logic [15:0] d1   [4][2];
    logic        v1   [4][2];
    logic [15:0] d2   [4][2];
    logic        v2   [4][2];
    logic        mcol [4];

    function automatic int depth_of(input int c);
        return (c == 3) ? 1000 : 2048;
    endfunction

    function automatic int mode_of(input int c);
        return (c == 1) ? 1 : (c == 2) ? 2 : 0;
    endfunction

    function automatic int addr_of(input int c, input logic [10:0] a);
        return (c == 3) ? int'(a[9:0]) : int'(a);
    endfunction

    function automatic logic [15:0] rd(input int c, input int a);
        return (a < depth_of(c)) ? mm[c][a] : 16'h0000;
    endfunction

    initial begin
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 2048; a++) mm[c][a] = 'x;
        end
    end

    // Word-level model: read old words, apply writes (A last so it wins), read new words.
    always @(posedge clk) begin : model
        exp_t        e;
        int          aa, ab;
        logic [15:0] old_a, old_b, new_a, new_b;
        for (int c = 0; c < 4; c++) begin
            aa = addr_of(c, addra);
            ab = addr_of(c, addrb);
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    d1[c][p] = 16'h0; v1[c][p] = 1'b0;
                    d2[c][p] = 16'h0; v2[c][p] = 1'b0;
                end
                mcol[c] = 1'b0;
            end else begin
                old_a = rd(c, aa);
                old_b = rd(c, ab);
                mcol[c] = ena && enb && (aa == ab) && (aa < depth_of(c)) && (wea != 0) && (web != 0);
                if (enb && ab < depth_of(c))
                    for (int i = 0; i < 2; i++) if (web[i]) mm[c][ab][i*8 +: 8] = dib[i*8 +: 8];
                if (ena && aa < depth_of(c))
                    for (int i = 0; i < 2; i++) if (wea[i]) mm[c][aa][i*8 +: 8] = dia[i*8 +: 8];
                new_a = rd(c, aa);
                new_b = rd(c, ab);
                for (int p = 0; p < 2; p++) begin
                    if (v1[c][p]) d2[c][p] = d1[c][p];
                    v2[c][p] = v1[c][p];
                end
                if (!ena || (wea != 0 && mode_of(c) == 2)) v1[c][0] = 1'b0;
                else begin
                    v1[c][0] = 1'b1;
                    d1[c][0] = (wea != 0 && mode_of(c) == 1) ? new_a : old_a;
                end
                if (!enb || (web != 0 && mode_of(c) == 2)) v1[c][1] = 1'b0;
                else begin
                    v1[c][1] = 1'b1;
                    d1[c][1] = (web != 0 && mode_of(c) == 1) ? new_b : old_b;
                end
            end
            e.doa[c]  = (c == 3) ? d2[c][0] : d1[c][0];
            e.dob[c]  = (c == 3) ? d2[c][1] : d1[c][1];
            e.va[c]   = (c == 3) ? v2[c][0] : v1[c][0];
            e.vb[c]   = (c == 3) ? v2[c][1] : v1[c][1];
            e.coll[c] = mcol[c];
        end
        exp_q.push_back(e);
    end

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin : scoreboard
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check("sb_queue_empty", 16'h0, 16'h1);
        end else begin
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                check($sformatf("sb_va_c%0d", c), {15'b0, va_q[c]}, {15'b0, e.va[c]});
                check($sformatf("sb_vb_c%0d", c), {15'b0, vb_q[c]}, {15'b0, e.vb[c]});
                check($sformatf("sb_coll_c%0d", c), {15'b0, coll_q[c]}, {15'b0, e.coll[c]});
                if (!$isunknown(e.doa[c])) check($sformatf("sb_doa_c%0d", c), doa_q[c], e.doa[c]);
                if (!$isunknown(e.dob[c])) check($sformatf("sb_dob_c%0d", c), dob_q[c], e.dob[c]);
            end
        end
    end

    // ---------------- directed vector table (read-first instance) ----------------
    typedef struct {
        logic        rst, ena, enb;
        logic [1:0]  wea, web;
        logic [10:0] addra, addrb;
        logic [15:0] dia, dib;
        logic [2:0]  chk;      // {check A, check B, check coll}
        logic [15:0] e_doa, e_dob;
        logic        e_va, e_vb, e_coll;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic r, input logic ea, input logic [1:0] wa, input logic [10:0] aa,
                                input logic [15:0] da, input logic eb, input logic [1:0] wb,
                                input logic [10:0] ab, input logic [15:0] db, input logic [2:0] chk,
                                input logic [15:0] eda, input logic eva, input logic [15:0] edb,
                                input logic evb, input logic ec);
        vec_t v;
        v.rst = r; v.ena = ea; v.wea = wa; v.addra = aa; v.dia = da;
        v.enb = eb; v.web = wb; v.addrb = ab; v.dib = db; v.chk = chk;
        v.e_doa = eda; v.e_va = eva; v.e_dob = edb; v.e_vb = evb; v.e_coll = ec;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        tbl[0]  = mk(0, 1, 2'b11, 5, 16'hBEEF, 0, 2'b00, 0, 16'h0,    3'b001, 16'h0,    0, 16'h0,    0, 0);
        tbl[1]  = mk(0, 0, 2'b00, 0, 16'h0,    1, 2'b00, 5, 16'h0,    3'b010, 16'h0,    0, 16'hBEEF, 1, 0);
        tbl[2]  = mk(0, 1, 2'b11, 7, 16'h1234, 0, 2'b00, 0, 16'h0,    3'b010, 16'h0,    0, 16'hBEEF, 0, 0);
        tbl[3]  = mk(0, 1, 2'b10, 7, 16'hAB00, 0, 2'b00, 0, 16'h0,    3'b100, 16'h1234, 1, 16'h0,    0, 0);
        tbl[4]  = mk(0, 0, 2'b00, 0, 16'h0,    1, 2'b00, 7, 16'h0,    3'b110, 16'h1234, 0, 16'hAB34, 1, 0);
        tbl[5]  = mk(0, 1, 2'b11, 9, 16'h1111, 1, 2'b01, 9, 16'h2222, 3'b001, 16'h0,    0, 16'h0,    0, 1);
        tbl[6]  = mk(0, 0, 2'b00, 0, 16'h0,    1, 2'b00, 9, 16'h0,    3'b011, 16'h0,    0, 16'h1111, 1, 0);
        tbl[7]  = mk(0, 1, 2'b10, 9, 16'h1111, 1, 2'b01, 9, 16'h2222, 3'b001, 16'h0,    0, 16'h0,    0, 1);
        tbl[8]  = mk(0, 1, 2'b00, 9, 16'h0,    0, 2'b00, 0, 16'h0,    3'b100, 16'h1122, 1, 16'h0,    0, 0);
        tbl[9]  = mk(0, 1, 2'b10, 9, 16'h3344, 1, 2'b01, 9, 16'h5566, 3'b101, 16'h1122, 1, 16'h0,    0, 1);
        tbl[10] = mk(0, 1, 2'b00, 9, 16'h0,    1, 2'b00, 9, 16'h0,    3'b111, 16'h3366, 1, 16'h3366, 1, 0);
        tbl[11] = mk(0, 1, 2'b11, 9, 16'h7777, 1, 2'b00, 9, 16'h0,    3'b111, 16'h3366, 1, 16'h3366, 1, 0);
        tbl[12] = mk(0, 0, 2'b00, 0, 16'h0,    1, 2'b00, 9, 16'h0,    3'b010, 16'h0,    0, 16'h7777, 1, 0);
        tbl[13] = mk(0, 0, 2'b00, 0, 16'h0,    0, 2'b00, 0, 16'h0,    3'b110, 16'h3366, 0, 16'h7777, 0, 0);
        tbl[14] = mk(1, 1, 2'b11, 9, 16'h0000, 1, 2'b00, 9, 16'h0,    3'b111, 16'h0,    0, 16'h0,    0, 0);
        tbl[15] = mk(0, 0, 2'b00, 0, 16'h0,    1, 2'b00, 9, 16'h0,    3'b011, 16'h0,    0, 16'h7777, 1, 0);

        drive(1, 0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0);
        repeat (3) tick();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("reset_doa_c%0d", c), doa_q[c], 16'h0);
            check($sformatf("reset_va_c%0d", c), {15'b0, va_q[c]}, 16'h0);
            check($sformatf("reset_coll_c%0d", c), {15'b0, coll_q[c]}, 16'h0);
        end

        // preload the addresses the random phase uses so every read is known
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, 2'b11, 11'(a), 16'($urandom), 0, 2'b00, 0, 16'h0);
            tick();
        end
        for (int a = 1000; a < 1024; a++) begin
            drive(0, 1, 2'b11, 11'(a), 16'($urandom), 0, 2'b00, 0, 16'h0);
            tick();
        end

        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].rst, tbl[k].ena, tbl[k].wea, tbl[k].addra, tbl[k].dia,
                  tbl[k].enb, tbl[k].web, tbl[k].addrb, tbl[k].dib);
            tick();
            if (tbl[k].chk[2]) begin
                check($sformatf("vec%0d_doa", k), doa_q[0], tbl[k].e_doa);
                check($sformatf("vec%0d_va", k), {15'b0, va_q[0]}, {15'b0, tbl[k].e_va});
            end
            if (tbl[k].chk[1]) begin
                check($sformatf("vec%0d_dob", k), dob_q[0], tbl[k].e_dob);
                check($sformatf("vec%0d_vb", k), {15'b0, vb_q[0]}, {15'b0, tbl[k].e_vb});
            end
            if (tbl[k].chk[0])
                check($sformatf("vec%0d_coll", k), {15'b0, coll_q[0]}, {15'b0, tbl[k].e_coll});
        end

        // read-during-write modes on address 3
        drive(0, 1, 2'b11, 3, 16'h0001, 0, 2'b00, 0, 16'h0); tick();
        drive(0, 1, 2'b00, 3, 16'h0, 0, 2'b00, 0, 16'h0);    tick();
        for (int c = 0; c < 3; c++) check($sformatf("rdw_pre_doa_c%0d", c), doa_q[c], 16'h0001);
        drive(0, 1, 2'b11, 3, 16'h00FF, 0, 2'b00, 0, 16'h0); tick();
        check("rdw_rf_doa", doa_q[0], 16'h0001);
        check("rdw_rf_va", {15'b0, va_q[0]}, 16'h1);
        check("rdw_wf_doa", doa_q[1], 16'h00FF);
        check("rdw_wf_va", {15'b0, va_q[1]}, 16'h1);
        check("rdw_nc_doa", doa_q[2], 16'h0001);
        check("rdw_nc_va", {15'b0, va_q[2]}, 16'h0);

        // registered output: latency and mid-stream reset flush
        drive(0, 0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0); tick(); tick();
        drive(0, 1, 2'b00, 3, 16'h0, 0, 2'b00, 0, 16'h0); tick();
        check("oreg_lat1_va", {15'b0, va_q[3]}, 16'h0);
        tick();
        check("oreg_lat2_va", {15'b0, va_q[3]}, 16'h1);
        check("oreg_lat2_doa", doa_q[3], 16'h00FF);
        rst = 1'b1; tick();
        check("oreg_rst0_va", {15'b0, va_q[3]}, 16'h0);
        check("oreg_rst0_doa", doa_q[3], 16'h0);
        rst = 1'b0; tick();
        check("oreg_rst1_va", {15'b0, va_q[3]}, 16'h0);
        check("oreg_rst1_doa", doa_q[3], 16'h0);
        tick();
        check("oreg_rst2_va", {15'b0, va_q[3]}, 16'h1);
        check("oreg_rst2_doa", doa_q[3], 16'h00FF);

        // out-of-range on the 1000-word instance
        drive(0, 1, 2'b11, 10, 16'h0A0A, 0, 2'b00, 0, 16'h0);   tick();
        drive(0, 1, 2'b11, 1010, 16'hDEAD, 0, 2'b00, 0, 16'h0); tick();
        drive(0, 1, 2'b00, 1010, 16'h0, 0, 2'b00, 0, 16'h0);    tick();
        drive(0, 1, 2'b00, 10, 16'h0, 0, 2'b00, 0, 16'h0);      tick();
        check("oor_doa", doa_q[3], 16'h0000);
        check("oor_va", {15'b0, va_q[3]}, 16'h1);
        drive(0, 0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0);       tick();
        check("oor_alias_doa", doa_q[3], 16'h0A0A);
        check("oor_alias_va", {15'b0, va_q[3]}, 16'h1);

        // randomized traffic, checked by the scoreboard
        for (int n = 0; n < 600; n++) begin
            logic [10:0] ra, rb;
            ra = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1000, 1023)) : 11'($urandom_range(0, 15));
            rb = ($urandom_range(0, 2) == 0) ? ra :
                 (($urandom_range(0, 9) == 0) ? 11'($urandom_range(1000, 1023)) : 11'($urandom_range(0, 15)));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra,
                  16'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rb, 16'($urandom));
            tick();
        end

        drive(0, 0, 2'b00, 0, 16'h0, 0, 2'b00, 0, 16'h0);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
